prbs23_check_ctrl: RTL and testbench

//  Sequencer for one external prbs23 instance (k=N=23, advances one 23-bit word per enable) used as a receive checker.

---
 rtl/prbs23_check_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_prbs23_check_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs23_check_ctrl.sv
// prbs23_check_ctrl
//   Receive-side sequencer for one external prbs23 generator. It seeds the
//   generator from the incoming word stream, requires LOCK_CNT consecutive
//   matching words before declaring lock, then counts words, errored words
//   and errored bits. LOSS_CNT consecutive errored words drop lock and
//   trigger an automatic reseed.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   enable            run the checker; low returns the FSM to IDLE
//   clear_cnt         synchronous clear of the three statistics counters
//   in_valid/in_data  received word stream (LSB = first bit on the line)
//   in_ready          word accepted when in_valid & in_ready
//   prbs_load/enable/seed/d  controls to the prbs23 instance
//   prbs_m            expected word from the prbs23 instance
//   locked            high while checking
//   sync_loss         one-cycle pulse when lock is lost
//   word_cnt, err_word_cnt, err_bit_cnt  saturating statistics counters
module prbs23_check_ctrl #(
   parameter int unsigned N        = 23,
   parameter int unsigned LOCK_CNT = 8,
   parameter int unsigned LOSS_CNT = 4,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             clear_cnt,
   input  logic             in_valid,
   input  logic [N-1:0]     in_data,
   output logic             in_ready,
   output logic             prbs_load,
   output logic             prbs_enable,
   output logic [N-1:0]     prbs_seed,
   output logic [N-1:0]     prbs_d,
   input  logic [N-1:0]     prbs_m,
   output logic             locked,
   output logic             sync_loss,
   output logic [CNT_W-1:0] word_cnt,
   output logic [CNT_W-1:0] err_word_cnt,
   output logic [CNT_W-1:0] err_bit_cnt
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SEED  = 3'd1;
   localparam logic [2:0] ST_PRIME = 3'd2;
   localparam logic [2:0] ST_LOCK  = 3'd3;
   localparam logic [2:0] ST_CHECK = 3'd4;

   localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
   localparam int unsigned MISS_W = $clog2(LOSS_CNT + 1);
   localparam int unsigned POP_W  = $clog2(N + 1);
   localparam int unsigned SUM_W  = CNT_W + POP_W;

   logic [2:0]        state_q, state_d;
   logic [RUN_W-1:0]  match_run_q, match_run_d;
   logic [MISS_W-1:0] miss_run_q, miss_run_d;
   logic              sync_loss_q, sync_loss_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]  err_word_cnt_q, err_word_cnt_d;
   logic [CNT_W-1:0]  err_bit_cnt_q, err_bit_cnt_d;

   logic              acc;
   logic              mis;
   logic [N-1:0]      diff;
   logic [POP_W-1:0]  pop;
   logic [SUM_W-1:0]  bit_sum;

   // Output decode: everything except sync_loss is a function of state
   // (plus the accept handshake for the generator strobes).
   assign in_ready    = (state_q == ST_SEED) || (state_q == ST_LOCK) || (state_q == ST_CHECK);
   assign acc         = in_valid & in_ready;
   assign diff        = in_data ^ prbs_m;
   assign mis         = |diff;
   // An all-zero seed would lock the LFSR up, so such words are dropped.
   assign prbs_load   = (state_q == ST_SEED) && acc && (|in_data);
   assign prbs_seed   = (state_q == ST_SEED) ? in_data : '0;
   assign prbs_enable = (state_q == ST_PRIME) ||
                        (((state_q == ST_LOCK) || (state_q == ST_CHECK)) && acc);
   assign prbs_d      = prbs_m;
   assign locked      = (state_q == ST_CHECK);
   assign sync_loss   = sync_loss_q;
   assign word_cnt     = word_cnt_q;
   assign err_word_cnt = err_word_cnt_q;
   assign err_bit_cnt  = err_bit_cnt_q;

   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pop = pop + POP_W'(diff[i]);
      end
   end

   always_comb begin
      state_d     = state_q;
      match_run_d = match_run_q;
      miss_run_d  = miss_run_q;
      sync_loss_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_SEED;
         end
         ST_SEED: begin
            if (prbs_load) state_d = ST_PRIME;
         end
         ST_PRIME: begin
            match_run_d = '0;
            state_d     = ST_LOCK;
         end
         ST_LOCK: begin
            if (acc) begin
               if (mis) begin
                  state_d = ST_SEED;
               end else begin
                  match_run_d = match_run_q + RUN_W'(1);
                  if (match_run_q == RUN_W'(LOCK_CNT - 1)) begin
                     state_d    = ST_CHECK;
                     miss_run_d = '0;
                  end
               end
            end
         end
         ST_CHECK: begin
            if (acc) begin
               if (mis) begin
                  miss_run_d = miss_run_q + MISS_W'(1);
                  if (miss_run_q == MISS_W'(LOSS_CNT - 1)) begin
                     state_d     = ST_SEED;
                     sync_loss_d = 1'b1;
                  end
               end else begin
                  miss_run_d = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Disable overrides every transition, including the sync-loss reseed.
      if (!enable) begin
         state_d     = ST_IDLE;
         sync_loss_d = 1'b0;
      end
   end

   always_comb begin
      word_cnt_d     = word_cnt_q;
      err_word_cnt_d = err_word_cnt_q;
      err_bit_cnt_d  = err_bit_cnt_q;
      // Widened add so the saturation test sees the carry out.
      bit_sum = {{POP_W{1'b0}}, err_bit_cnt_q} + {{CNT_W{1'b0}}, pop};
      if (clear_cnt) begin
         word_cnt_d     = '0;
         err_word_cnt_d = '0;
         err_bit_cnt_d  = '0;
      end else if ((state_q == ST_CHECK) && acc) begin
         word_cnt_d = (&word_cnt_q) ? word_cnt_q : word_cnt_q + CNT_W'(1);
         if (mis) begin
            err_word_cnt_d = (&err_word_cnt_q) ? err_word_cnt_q : err_word_cnt_q + CNT_W'(1);
         end
         err_bit_cnt_d = (|bit_sum[SUM_W-1:CNT_W]) ? '1 : bit_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         match_run_q    <= '0;
         miss_run_q     <= '0;
         sync_loss_q    <= 1'b0;
         word_cnt_q     <= '0;
         err_word_cnt_q <= '0;
         err_bit_cnt_q  <= '0;
      end else begin
         state_q        <= state_d;
         match_run_q    <= match_run_d;
         miss_run_q     <= miss_run_d;
         sync_loss_q    <= sync_loss_d;
         word_cnt_q     <= word_cnt_d;
         err_word_cnt_q <= err_word_cnt_d;
         err_bit_cnt_q  <= err_bit_cnt_d;
      end
   end

endmodule

// File: tb/tb_prbs23_check_ctrl.sv
// tb_prbs23_check_ctrl
//   Directed bench for prbs23_check_ctrl. Two instances share the input
//   stream: a default one and a CNT_W=4 one for counter saturation. Each has
//   its own behavioural prbs23 generator (x^23 + x^18 + 1, 23 bits per step).
module tb_prbs23_check_ctrl;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        clear_cnt;
   logic        in_valid;
   logic [22:0] in_data;

   logic        in_ready, prbs_load, prbs_enable, locked, sync_loss;
   logic [22:0] prbs_seed, prbs_d, prbs_m;
   logic [31:0] word_cnt, err_word_cnt, err_bit_cnt;

   logic        in_ready4, prbs_load4, prbs_enable4, locked4, sync_loss4;
   logic [22:0] prbs_seed4, prbs_d4, prbs_m4;
   logic [3:0]  word_cnt4, err_word_cnt4, err_bit_cnt4;

   int          n_vec;
   int          n_mis;
   int          n_sync;
   int          st;
   logic [22:0] tx;

   prbs23_check_ctrl dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear_cnt(clear_cnt),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .prbs_load(prbs_load), .prbs_enable(prbs_enable), .prbs_seed(prbs_seed),
      .prbs_d(prbs_d), .prbs_m(prbs_m), .locked(locked), .sync_loss(sync_loss),
      .word_cnt(word_cnt), .err_word_cnt(err_word_cnt), .err_bit_cnt(err_bit_cnt)
   );

   prbs23_check_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear_cnt(clear_cnt),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
      .prbs_load(prbs_load4), .prbs_enable(prbs_enable4), .prbs_seed(prbs_seed4),
      .prbs_d(prbs_d4), .prbs_m(prbs_m4), .locked(locked4), .sync_loss(sync_loss4),
      .word_cnt(word_cnt4), .err_word_cnt(err_word_cnt4), .err_bit_cnt(err_bit_cnt4)
   );

   // Stream bit b[n] = b[n-23] ^ b[n-18]; word LSB is the earliest bit.
   function automatic logic [22:0] nxt(input logic [22:0] w);
      logic [22:0] nw;
      nw = '0;
      for (int i = 0; i < 23; i++) begin
         if (i + 5 < 23) nw[i] = w[i] ^ w[i+5];
         else            nw[i] = w[i] ^ nw[i-18];
      end
      return nw;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          prbs_m <= '0;
      else if (prbs_load)  prbs_m <= prbs_seed;
      else if (prbs_enable) prbs_m <= nxt(prbs_m);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           prbs_m4 <= '0;
      else if (prbs_load4)  prbs_m4 <= prbs_seed4;
      else if (prbs_enable4) prbs_m4 <= nxt(prbs_m4);
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (sync_loss) n_sync++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Presents one word until accepted (bounded); returns cycles stalled.
   task automatic send(input logic [22:0] w, output int stalls);
      logic a;
      a = 1'b0;
      stalls = 0;
      in_valid = 1'b1;
      in_data  = w;
      for (int k = 0; k < 8 && !a; k++) begin
         a = in_ready;
         if (!a) stalls++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!a) chk("accept_timeout", {31'd0, a}, 32'd1);
   endtask

   task automatic send_clean(input int n);
      int s;
      for (int k = 0; k < n; k++) begin
         tx = nxt(tx);
         send(tx, s);
      end
   endtask

   task automatic pulse_clear();
      clear_cnt = 1'b1;
      @(posedge clk);
      #1;
      clear_cnt = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_mis = 0; n_sync = 0;
      rst_n = 1'b1; enable = 1'b0; clear_cnt = 1'b0; in_valid = 1'b0; in_data = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_locked", {31'd0, locked}, 32'd0);
      chk("rst_word_cnt", word_cnt, 32'd0);
      chk("rst_prbs_enable", {31'd0, prbs_enable}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      enable = 1'b1;
      @(posedge clk); #1;
      chk("seed_ready", {31'd0, in_ready}, 32'd1);

      // 1: seed 1, relock over 8 words with a one-cycle PRIME bubble
      tx = 23'h000001;
      send(tx, st);
      chk("seed_stall", st, 32'd0);
      chk("prime_ready", {31'd0, in_ready}, 32'd0);
      tx = nxt(tx);
      send(tx, st);
      chk("prime_bubble", st, 32'd1);
      send_clean(6);
      chk("lock_after7", {31'd0, locked}, 32'd0);
      send_clean(1);
      chk("lock_after8", {31'd0, locked}, 32'd1);
      chk("lock_words_uncounted", word_cnt, 32'd0);
      send_clean(100);
      chk("t1_word_cnt", word_cnt, 32'd100);
      chk("t1_err_word", err_word_cnt, 32'd0);
      chk("t1_err_bit", err_bit_cnt, 32'd0);

      // 2: single bit error keeps lock
      tx = nxt(tx);
      send(tx ^ 23'h1, st);
      chk("t2_err_word", err_word_cnt, 32'd1);
      chk("t2_err_bit", err_bit_cnt, 32'd1);
      send_clean(3);
      chk("t2_locked", {31'd0, locked}, 32'd1);
      chk("t2_no_sync_loss", n_sync, 32'd0);
      chk("t2_word_cnt", word_cnt, 32'd104);

      // 3: four consecutive 3-bit errors lose sync, then relock
      pulse_clear();
      chk("t3_clr_word", word_cnt, 32'd0);
      chk("t3_clr_bit", err_bit_cnt, 32'd0);
      for (int k = 0; k < 3; k++) begin
         tx = nxt(tx);
         send(tx ^ 23'h7, st);
      end
      chk("t3_locked_at3", {31'd0, locked}, 32'd1);
      tx = nxt(tx);
      send(tx ^ 23'h7, st);
      chk("t3_sync_loss", {31'd0, sync_loss}, 32'd1);
      chk("t3_unlocked", {31'd0, locked}, 32'd0);
      chk("t3_err_word", err_word_cnt, 32'd4);
      chk("t3_err_bit", err_bit_cnt, 32'd12);
      chk("t3_word_cnt", word_cnt, 32'd4);
      @(posedge clk); #1;
      chk("t3_pulse_end", {31'd0, sync_loss}, 32'd0);
      chk("t3_pulse_count", n_sync, 32'd1);
      tx = nxt(tx);
      send(tx, st);
      send_clean(8);
      chk("t3_relock", {31'd0, locked}, 32'd1);

      // 5b: disable mid-CHECK
      enable = 1'b0;
      @(posedge clk); #1;
      chk("t5_idle_ready", {31'd0, in_ready}, 32'd0);
      chk("t5_idle_locked", {31'd0, locked}, 32'd0);
      enable = 1'b1;
      @(posedge clk); #1;

      // 4: zero word in SEED is dropped, next nonzero word seeds
      in_valid = 1'b1; in_data = '0;
      #1;
      chk("t4_zero_no_load", {31'd0, prbs_load}, 32'd0);
      send(23'h0, st);
      chk("t4_stay_seed", {31'd0, in_ready}, 32'd1);
      tx = nxt(tx);
      in_valid = 1'b1; in_data = tx;
      #1;
      chk("t4_load", {31'd0, prbs_load}, 32'd1);
      chk("t4_seed", {9'd0, prbs_seed}, {9'd0, tx});
      send(tx, st);
      chk("t4_prime", {31'd0, in_ready}, 32'd0);

      // 5a: mismatch at 5th LOCK word returns to SEED, counters untouched
      send_clean(4);
      tx = nxt(tx);
      send(tx ^ 23'h100, st);
      chk("t5_seed_ready", {31'd0, in_ready}, 32'd1);
      chk("t5_locked", {31'd0, locked}, 32'd0);
      chk("t5_word_cnt", word_cnt, 32'd4);
      chk("t5_err_word", err_word_cnt, 32'd4);
      chk("t5_err_bit", err_bit_cnt, 32'd12);
      tx = nxt(tx);
      send(tx, st);
      send_clean(8);
      chk("t5_relock", {31'd0, locked}, 32'd1);

      // 6: saturation on the 4-bit instance, clear wins, async reset
      pulse_clear();
      for (int k = 0; k < 20; k++) begin
         tx = nxt(tx);
         send(tx ^ 23'h1, st);
         send_clean(1);
      end
      chk("t6_locked", {31'd0, locked}, 32'd1);
      chk("t6_err_word", err_word_cnt, 32'd20);
      chk("t6_err_bit", err_bit_cnt, 32'd20);
      chk("t6_word", word_cnt, 32'd40);
      chk("t6_err_word4", {28'd0, err_word_cnt4}, 32'hF);
      chk("t6_err_bit4", {28'd0, err_bit_cnt4}, 32'hF);
      chk("t6_word4", {28'd0, word_cnt4}, 32'hF);
      clear_cnt = 1'b1;
      tx = nxt(tx);
      send(tx ^ 23'h1, st);
      clear_cnt = 1'b0;
      chk("t6_clr_word", word_cnt, 32'd0);
      chk("t6_clr_err_word", err_word_cnt, 32'd0);
      chk("t6_clr_err_bit", err_bit_cnt, 32'd0);
      chk("t6_clr_err_word4", {28'd0, err_word_cnt4}, 32'd0);
      send_clean(3);
      chk("t6_pre_rst_word", word_cnt, 32'd3);
      rst_n = 1'b0;
      #2;
      chk("t6_rst_locked", {31'd0, locked}, 32'd0);
      chk("t6_rst_ready", {31'd0, in_ready}, 32'd0);
      chk("t6_rst_word", word_cnt, 32'd0);
      chk("t6_rst_word4", {28'd0, word_cnt4}, 32'd0);
      chk("t6_rst_prbs_en", {31'd0, prbs_enable}, 32'd0);
      chk("t6_rst_sync", {31'd0, sync_loss}, 32'd0);
      #10;
      rst_n = 1'b1;
      #10;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
